// File: rtl/freelist_return_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : freelist_return_ctrl_pkg
// Brief   : Shared tag width, lane count default, FSM state enum and helpers
//           for the freelist return path.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef N
`define N 2
`endif

package freelist_return_ctrl_pkg;

   localparam int PHYS_TAG = 7;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      WALK   = 2'd1,
      DRAIN  = 2'd2
   } FL_RET_STATE;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input int b);
      logic [32:0] s;
      s = {1'b0, a} + 33'(b);
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/fl_return_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fl_return_fifo
// Brief   : DEPTH-entry circular FIFO, up to N pushes and N pops per cycle,
//           with the N oldest entries always visible on peek_data.
// Revision: 1.0 - initial release
// ============================================================================
module fl_return_fifo #(
   parameter int N     = 2,
   parameter int DEPTH = 8,
   parameter int W     = 7,
   parameter int LW    = $clog2(N + 1),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [LW-1:0]        push_cnt,
   input  logic [N-1:0][W-1:0]  push_data,
   input  logic [LW-1:0]        pop_cnt,
   output logic [N-1:0][W-1:0]  peek_data,
   output logic [CW-1:0]        count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Offsets never exceed N <= DEPTH/2, so one conditional subtract is a full modulo.
   function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= DEPTH) s = s - DEPTH;
      return PW'(s);
   endfunction

   always_comb begin
      peek_data = '0;
      for (int j = 0; j < N; j++) peek_data[j] = mem[wrap(rd_ptr, j)];
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < N; i++) begin
         if (i < int'(push_cnt)) mem[wrap(wr_ptr, i)] <= push_data[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wrap(wr_ptr, int'(push_cnt));
         rd_ptr <= wrap(rd_ptr, int'(pop_cnt));
         count  <= CW'(int'(count) + int'(push_cnt) - int'(pop_cnt));
      end
   end

endmodule

`default_nettype wire

// File: rtl/freelist_return_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : freelist_return_ctrl
// Brief   : Merges retire and squash tag returns into the freelist lanes with
//           an overflow FIFO; FREELIST_RETURN_STATS_EN adds stat counters.
// Revision: 1.0 - initial release
// ============================================================================
module freelist_return_ctrl
   import freelist_return_ctrl_pkg::*;
#(
   parameter int N     = `N,
   parameter int DEPTH = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N-1:0]                retire_valid,
   input  logic [N-1:0][PHYS_TAG-1:0]  retire_tag,
   input  logic                        recover_start,
   input  logic                        recover_done,
   input  logic [N-1:0]                squash_valid,
   input  logic [N-1:0][PHYS_TAG-1:0]  squash_tag,
   output logic                        squash_ready,
   output logic                        recover_busy,
   output logic [N-1:0]                fl_retire_en,
   output logic [N-1:0][PHYS_TAG-1:0]  fl_retire_reg
`ifdef FREELIST_RETURN_STATS_EN
   ,
   output logic [31:0]                 stat_retire_cnt,
   output logic [31:0]                 stat_squash_cnt,
   output logic [31:0]                 stat_stall_cycles
`endif
);

   localparam int LW = $clog2(N + 1);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   FL_RET_STATE                 state, state_next;
   logic [CW-1:0]               fifo_count, count_next;
   logic [LW-1:0]               push_cnt, pop_cnt;
   logic [N-1:0][PHYS_TAG-1:0]  push_data, peek_data;
   logic [N-1:0]                sel_en;
   logic [N-1:0][PHYS_TAG-1:0]  sel_reg;
   logic [N-1:0]                squash_acc;
   logic                        ready_next;
`ifdef FREELIST_RETURN_STATS_EN
   int                          retire_fwd, squash_fwd;
`endif

   fl_return_fifo #(
      .N     (N),
      .DEPTH (DEPTH),
      .W     (PHYS_TAG),
      .LW    (LW),
      .CW    (CW)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop_cnt   (pop_cnt),
      .peek_data (peek_data),
      .count     (fifo_count)
   );

   assign squash_acc = squash_valid & {N{squash_ready && (state == WALK)}};

   // Slots are filled retire -> FIFO -> squash; squash only reaches a slot once the FIFO is exhausted.
   always_comb begin
      int slot, popc, pushc, nfifo;
      sel_en    = '0;
      sel_reg   = '0;
      push_data = '0;
      slot      = 0;
      popc      = 0;
      pushc     = 0;
      nfifo     = int'(fifo_count);
`ifdef FREELIST_RETURN_STATS_EN
      retire_fwd = 0;
      squash_fwd = 0;
`endif
      for (int i = 0; i < N; i++) begin
         if (retire_valid[i] && (retire_tag[i] != '0)) begin
            sel_en[IW'(slot)]  = 1'b1;
            sel_reg[IW'(slot)] = retire_tag[i];
            slot = slot + 1;
`ifdef FREELIST_RETURN_STATS_EN
            retire_fwd = retire_fwd + 1;
`endif
         end
      end
      for (int j = 0; j < N; j++) begin
         if ((j < nfifo) && (slot < N)) begin
            sel_en[IW'(slot)]  = 1'b1;
            sel_reg[IW'(slot)] = peek_data[j];
            slot = slot + 1;
            popc = popc + 1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (squash_acc[i] && (squash_tag[i] != '0)) begin
            if (slot < N) begin
               sel_en[IW'(slot)]  = 1'b1;
               sel_reg[IW'(slot)] = squash_tag[i];
               slot = slot + 1;
            end else begin
               push_data[IW'(pushc)] = squash_tag[i];
               pushc = pushc + 1;
            end
         end
      end
`ifdef FREELIST_RETURN_STATS_EN
      squash_fwd = slot - retire_fwd;
`endif
      pop_cnt    = LW'(popc);
      push_cnt   = LW'(pushc);
      count_next = CW'(nfifo + pushc - popc);
   end

   always_comb begin
      state_next = state;
      case (state)
         NORMAL: if (recover_start) state_next = WALK;
         WALK:   if (recover_done)  state_next = (count_next == '0) ? NORMAL : DRAIN;
         DRAIN:  if (fifo_count == '0) state_next = NORMAL;
         default: state_next = NORMAL;
      endcase
      ready_next = (state_next == WALK) && ((DEPTH - int'(count_next)) >= N);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= NORMAL;
         squash_ready  <= 1'b0;
         recover_busy  <= 1'b0;
         fl_retire_en  <= '0;
         fl_retire_reg <= '0;
      end else begin
         state         <= state_next;
         squash_ready  <= ready_next;
         recover_busy  <= (state_next != NORMAL);
         fl_retire_en  <= sel_en;
         fl_retire_reg <= sel_reg;
      end
   end

`ifdef FREELIST_RETURN_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_retire_cnt   <= '0;
         stat_squash_cnt   <= '0;
         stat_stall_cycles <= '0;
      end else begin
         stat_retire_cnt   <= sat_add32(stat_retire_cnt, retire_fwd);
         stat_squash_cnt   <= sat_add32(stat_squash_cnt, squash_fwd);
         stat_stall_cycles <= sat_add32(stat_stall_cycles,
                                        ((state == WALK) && !squash_ready) ? 1 : 0);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_freelist_return_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_freelist_return_ctrl
// Brief   : Directed scoreboard bench for freelist_return_ctrl, N=2 DEPTH=8.
// Revision: 1.0 - initial release
// ============================================================================
module tb_freelist_return_ctrl;
   import freelist_return_ctrl_pkg::*;

   localparam int N = 2;
   localparam int DEPTH = 8;

   logic                        clock = 1'b0;
   logic                        reset = 1'b1;
   logic [N-1:0]                retire_valid = '0;
   logic [N-1:0][PHYS_TAG-1:0]  retire_tag = '0;
   logic                        recover_start = 1'b0;
   logic                        recover_done = 1'b0;
   logic [N-1:0]                squash_valid = '0;
   logic [N-1:0][PHYS_TAG-1:0]  squash_tag = '0;
   logic                        squash_ready;
   logic                        recover_busy;
   logic [N-1:0]                fl_retire_en;
   logic [N-1:0][PHYS_TAG-1:0]  fl_retire_reg;

   freelist_return_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
      .clock         (clock),
      .reset         (reset),
      .retire_valid  (retire_valid),
      .retire_tag    (retire_tag),
      .recover_start (recover_start),
      .recover_done  (recover_done),
      .squash_valid  (squash_valid),
      .squash_tag    (squash_tag),
      .squash_ready  (squash_ready),
      .recover_busy  (recover_busy),
      .fl_retire_en  (fl_retire_en),
      .fl_retire_reg (fl_retire_reg)
   );

   always #5 clock = ~clock;

   typedef struct {
      int                  cyc;
      int                  row;
      logic [N-1:0]        en;
      logic [PHYS_TAG-1:0] r0;
      logic [PHYS_TAG-1:0] r1;
      logic                rdy;
      logic                busy;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   rown = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input int r, input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s row %0d: got %0d, expected %0d", name, r, got, want);
      end
   endtask

   // Each row's expected response is checked in the cycle after it was driven.
   always @(posedge clock) begin
      #3;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         exp_t e;
         e = q.pop_front();
         chk("fl_retire_en",     e.row, 32'(fl_retire_en),     32'(e.en));
         chk("fl_retire_reg0",   e.row, 32'(fl_retire_reg[0]), 32'(e.r0));
         chk("fl_retire_reg1",   e.row, 32'(fl_retire_reg[1]), 32'(e.r1));
         chk("squash_ready",     e.row, 32'(squash_ready),     32'(e.rdy));
         chk("recover_busy",     e.row, 32'(recover_busy),     32'(e.busy));
      end
   end

   task automatic row(input logic rst_i,
                      input logic [1:0] rv, input int rt0, input int rt1,
                      input logic rs, input logic rd,
                      input logic [1:0] sv, input int st0, input int st1,
                      input logic [1:0] een, input int er0, input int er1,
                      input logic erdy, input logic ebusy);
      exp_t e;
      @(posedge clock);
      #1;
      reset         = rst_i;
      retire_valid  = rv;
      retire_tag[0] = PHYS_TAG'(rt0);
      retire_tag[1] = PHYS_TAG'(rt1);
      recover_start = rs;
      recover_done  = rd;
      squash_valid  = sv;
      squash_tag[0] = PHYS_TAG'(st0);
      squash_tag[1] = PHYS_TAG'(st1);
      e.cyc  = cyc;
      e.row  = rown;
      e.en   = een;
      e.r0   = PHYS_TAG'(er0);
      e.r1   = PHYS_TAG'(er1);
      e.rdy  = erdy;
      e.busy = ebusy;
      q.push_back(e);
      rown = rown + 1;
   endtask

   initial begin
      //   rst rv    rt0 rt1 rs rd sv    st0 st1   en    r0  r1 rdy busy
      row(1, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b00,  0,  0, 0, 0);
      row(1, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b00,  0,  0, 0, 0);
      row(0, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b00,  0,  0, 0, 0);
      row(0, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b00,  0,  0, 0, 0);
      // lane 1 retire compacts onto lane 0
      row(0, 2'b10,  0,  5, 0, 0, 2'b00,  0,  0,  2'b01,  5,  0, 0, 0);
      row(0, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b00,  0,  0, 0, 0);
      // squash alongside recover_start is ignored
      row(0, 2'b00,  0,  0, 1, 0, 2'b11,  3,  4,  2'b00,  0,  0, 1, 1);
      row(0, 2'b11, 20, 21, 0, 0, 2'b11,  7,  8,  2'b11, 20, 21, 1, 1);
      row(0, 2'b11, 22, 23, 0, 0, 2'b11,  9, 10,  2'b11, 22, 23, 1, 1);
      row(0, 2'b11, 24, 25, 0, 0, 2'b01, 11,  0,  2'b11, 24, 25, 1, 1);
      // count reaches 7: ready drops
      row(0, 2'b11, 26, 27, 0, 0, 2'b11, 12, 13,  2'b11, 26, 27, 0, 1);
      row(0, 2'b11, 28, 29, 0, 0, 2'b11, 50, 51,  2'b11, 28, 29, 0, 1);
      row(0, 2'b11, 30, 31, 0, 0, 2'b00,  0,  0,  2'b11, 30, 31, 0, 1);
      row(0, 2'b01, 32,  0, 0, 0, 2'b00,  0,  0,  2'b11, 32,  7, 1, 1);
      // done with a squash group in the same cycle
      row(0, 2'b00,  0,  0, 0, 1, 2'b11, 14, 15,  2'b11,  8,  9, 0, 1);
      row(0, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b11, 10, 11, 0, 1);
      row(0, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b11, 12, 13, 0, 1);
      row(0, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b11, 14, 15, 0, 1);
      row(0, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b00,  0,  0, 0, 0);
      // tag 0 is dropped
      row(0, 2'b11,  0, 12, 0, 0, 2'b00,  0,  0,  2'b01, 12,  0, 0, 0);
      row(0, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b00,  0,  0, 0, 0);
      row(0, 2'b00,  0,  0, 1, 0, 2'b00,  0,  0,  2'b00,  0,  0, 1, 1);
      row(0, 2'b11, 60, 61, 0, 0, 2'b11, 40, 41,  2'b11, 60, 61, 1, 1);
      row(0, 2'b11, 62, 63, 0, 0, 2'b11, 42, 43,  2'b11, 62, 63, 1, 1);
      row(0, 2'b11, 64, 65, 0, 1, 2'b00,  0,  0,  2'b11, 64, 65, 0, 1);
      // reset in DRAIN with 4 buffered, then FIFO must be empty
      row(1, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b00,  0,  0, 0, 0);
      row(0, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b00,  0,  0, 0, 0);
      // done with empty FIFO goes straight back to NORMAL
      row(0, 2'b00,  0,  0, 1, 0, 2'b00,  0,  0,  2'b00,  0,  0, 1, 1);
      row(0, 2'b00,  0,  0, 0, 1, 2'b01, 44,  0,  2'b01, 44,  0, 0, 0);
      row(0, 2'b00,  0,  0, 0, 0, 2'b00,  0,  0,  2'b00,  0,  0, 0, 0);
      repeat (3) @(posedge clock);
      #4;
      checks = checks + 1;
      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
